// File: rtl/dual_fetch_unit.sv
// Dual-issue fetch stage: issues 64-bit instruction-pair requests, queues the
// in-order responses and presents the head pair with its PC to IF/ID.
module dual_fetch_unit #(
  parameter int unsigned QDEPTH   = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data1,
  input  logic [31:0] imem_rsp_data2,
  output logic [31:0] instruction1,
  output logic [31:0] instruction2,
  output logic [31:0] fetch_pc,
  output logic        fetch_valid
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data1;
    logic [31:0] data2;
  } entry_t;

  localparam logic [31:0] PC_ALIGN = 32'hFFFF_FFFC;
  localparam logic [31:0] PAIR_STEP = 32'd8;
  localparam cnt_t DEPTH_C = cnt_t'(QDEPTH);

  if (QDEPTH < 2 || (QDEPTH & (QDEPTH - 1)) != 0) begin : g_bad_depth
    $error("dual_fetch_unit: QDEPTH must be a power of 2 and at least 2");
  end

  entry_t queue_mem [QDEPTH];
  ptr_t   rd_ptr;
  ptr_t   wr_ptr;
  cnt_t   count;
  cnt_t   inflight;
  cnt_t   drop;
  logic [31:0] pc;
  logic [31:0] rsp_pc;

  cnt_t        live;
  logic [CW:0] occupancy;
  logic        req_fire;
  logic        push;
  logic        pop;
  entry_t      head;

  // Requests are credited against queue space plus responses still to be kept,
  // so every accepted response is guaranteed a slot.
  assign live      = inflight - drop;
  assign occupancy = {1'b0, count} + {1'b0, live};

  assign imem_req_valid = !reset && !flush
                        && (occupancy < (CW + 1)'(QDEPTH))
                        && (inflight < DEPTH_C);
  assign imem_addr = pc;
  assign req_fire  = imem_req_valid && imem_ready;

  assign push = imem_rsp_valid && !flush && (drop == '0);
  assign pop  = !stall && !flush && (count != '0);

  assign head         = queue_mem[rd_ptr];
  assign fetch_valid  = (count != '0);
  assign instruction1 = fetch_valid ? head.data1 : 32'h0;
  assign instruction2 = fetch_valid ? head.data2 : 32'h0;
  assign fetch_pc     = fetch_valid ? head.pc    : 32'h0;

  // NOTE: all sequential state uses non-blocking assignments so every register
  // in this block sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC & PC_ALIGN;
      rsp_pc <= RESET_PC & PC_ALIGN;
    end else if (flush) begin
      pc     <= redirect_pc & PC_ALIGN;
      rsp_pc <= redirect_pc & PC_ALIGN;
    end else begin
      if (req_fire) pc <= pc + PAIR_STEP;
      if (push)     rsp_pc <= rsp_pc + PAIR_STEP;
    end
  end

  // req_fire is already zero during flush, so one update covers both cases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight + cnt_t'(req_fire) - cnt_t'(imem_rsp_valid);
      if (flush)
        drop <= inflight - cnt_t'(imem_rsp_valid);
      else if (imem_rsp_valid && (drop != '0))
        drop <= drop - cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      case ({push, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the queue storage has no reset; entries are only observed while
  // count is non-zero, and skipping the reset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (push) queue_mem[wr_ptr] <= '{pc: rsp_pc, data1: imem_rsp_data1, data2: imem_rsp_data2};
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
    push |-> (count < DEPTH_C));

  a_no_orphan_response: assert property (@(posedge clk) disable iff (reset)
    imem_rsp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Directed bench for dual_fetch_unit: a cycle table for streaming/stall/flush/wrap
// plus hand-written sequences for async reset and a 3-cycle-latency flush.
module tb_dual_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data1;
  logic [31:0] imem_rsp_data2;
  logic [31:0] instruction1;
  logic [31:0] instruction2;
  logic [31:0] fetch_pc;
  logic        fetch_valid;

  int n_checks = 0;
  int n_fail   = 0;

  dual_fetch_unit #(.QDEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data1 (imem_rsp_data1),
    .imem_rsp_data2 (imem_rsp_data2),
    .instruction1   (instruction1),
    .instruction2   (instruction2),
    .fetch_pc       (fetch_pc),
    .fetch_valid    (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // In-order memory model: data1 = address, data2 = address + 4, fixed latency.
  typedef struct {
    logic [31:0] addr;
    int unsigned issue;
  } mreq_t;

  mreq_t       mq[$];
  int unsigned cyc     = 0;
  int unsigned mem_lat = 1;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data1 <= 32'h0;
      imem_rsp_data2 <= 32'h0;
    end else begin
      if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
      if (imem_req_valid && imem_ready) mq.push_back('{imem_addr, cyc});
      cyc++;
      if (mq.size() > 0 && cyc >= mq[0].issue + mem_lat) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data1 <= mq[0].addr;
        imem_rsp_data2 <= mq[0].addr + 32'd4;
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  typedef struct {
    logic        stall;
    logic        flush;
    logic        ready;
    logic [31:0] redirect;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_fv;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add_row(input logic s, input logic f, input logic r, input logic [31:0] rp,
                         input logic er, input logic [31:0] ea, input logic ef,
                         input logic [31:0] ep);
    vecs.push_back('{s, f, r, rp, er, ea, ef, ep});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic fv, input logic [31:0] pcv);
    check({tag, " fetch_valid"},  32'(fetch_valid), 32'(fv));
    check({tag, " fetch_pc"},     fetch_pc,      fv ? pcv : 32'h0);
    check({tag, " instruction1"}, instruction1,  fv ? pcv : 32'h0);
    check({tag, " instruction2"}, instruction2,  fv ? pcv + 32'd4 : 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Cycle table, 1-cycle memory, starting right after reset release.
    add_row(1,0,1,32'h0,        1,32'h0,        0,32'h0);        // 0
    add_row(1,0,1,32'h0,        1,32'h8,        0,32'h0);        // 1
    add_row(1,0,1,32'h0,        1,32'h10,       1,32'h0);        // 2 first pair
    add_row(1,0,1,32'h0,        1,32'h18,       1,32'h0);        // 3
    add_row(1,0,1,32'h0,        0,32'h20,       1,32'h0);        // 4 credits exhausted
    add_row(1,0,1,32'h0,        0,32'h20,       1,32'h0);        // 5
    add_row(1,0,1,32'h0,        0,32'h20,       1,32'h0);        // 6
    add_row(0,0,1,32'h0,        0,32'h20,       1,32'h0);        // 7 stall released
    add_row(0,0,1,32'h0,        1,32'h20,       1,32'h8);        // 8
    add_row(0,0,1,32'h0,        1,32'h28,       1,32'h10);       // 9
    add_row(0,0,1,32'h0,        1,32'h30,       1,32'h18);       // 10
    add_row(0,0,1,32'h0,        1,32'h38,       1,32'h20);       // 11
    add_row(0,0,0,32'h0,        1,32'h40,       1,32'h28);       // 12 ready low
    add_row(0,0,0,32'h0,        1,32'h40,       1,32'h30);       // 13
    add_row(0,0,0,32'h0,        1,32'h40,       1,32'h38);       // 14
    add_row(0,0,1,32'h0,        1,32'h40,       0,32'h0);        // 15 queue drained
    add_row(0,0,1,32'h0,        1,32'h48,       0,32'h0);        // 16
    add_row(1,0,1,32'h0,        1,32'h50,       1,32'h40);       // 17 build count=2
    add_row(1,1,1,32'h200,      0,32'h58,       1,32'h40);       // 18 flush+stall
    add_row(0,0,1,32'h0,        1,32'h200,      0,32'h0);        // 19
    add_row(0,0,1,32'h0,        1,32'h208,      0,32'h0);        // 20
    add_row(0,0,1,32'h0,        1,32'h210,      1,32'h200);      // 21
    add_row(0,1,1,32'hFFFF_FFF8,0,32'h218,      1,32'h208);      // 22 flush to top
    add_row(0,0,1,32'h0,        1,32'hFFFF_FFF8,0,32'h0);        // 23
    add_row(0,0,1,32'h0,        1,32'h0,        0,32'h0);        // 24 wrapped
    add_row(0,0,1,32'h0,        1,32'h8,        1,32'hFFFF_FFF8);// 25
    add_row(0,1,1,32'h103,      0,32'h10,       1,32'h0);        // 26 unaligned redirect
    add_row(0,0,1,32'h0,        1,32'h100,      0,32'h0);        // 27

    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
    next_cycle();
    next_cycle();
    check("reset req_valid", 32'(imem_req_valid), 32'h0);
    check("reset imem_addr", imem_addr, 32'h0);
    check_head("reset", 1'b0, 32'h0);

    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      stall       = vecs[i].stall;
      flush       = vecs[i].flush;
      imem_ready  = vecs[i].ready;
      redirect_pc = vecs[i].redirect;
      @(negedge clk);
      check($sformatf("row%0d req_valid", i), 32'(imem_req_valid), 32'(vecs[i].exp_req));
      check($sformatf("row%0d imem_addr", i), imem_addr, vecs[i].exp_addr);
      check_head($sformatf("row%0d", i), vecs[i].exp_fv, vecs[i].exp_pc);
      next_cycle();
    end

    // Stream two more cycles, then assert reset between edges.
    stall = 1'b0; flush = 1'b0; imem_ready = 1'b1; redirect_pc = 32'h0;
    next_cycle();
    @(negedge clk);
    check_head("pre-reset", 1'b1, 32'h100);
    next_cycle();
    reset = 1'b1;
    #1;
    check("async reset req_valid", 32'(imem_req_valid), 32'h0);
    check("async reset imem_addr", imem_addr, 32'h0);
    check_head("async reset", 1'b0, 32'h0);

    // 3-cycle memory, flush while two requests are outstanding.
    mem_lat = 3;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("lat3 c0 imem_addr", imem_addr, 32'h0);
    check("lat3 c0 req_valid", 32'(imem_req_valid), 32'h1);
    next_cycle();
    @(negedge clk);
    check("lat3 c1 imem_addr", imem_addr, 32'h8);
    next_cycle();
    flush = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    check("lat3 flush req_valid", 32'(imem_req_valid), 32'h0);
    next_cycle();
    flush = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    check("lat3 c3 imem_addr", imem_addr, 32'h100);
    check("lat3 c3 req_valid", 32'(imem_req_valid), 32'h1);
    check_head("lat3 c3", 1'b0, 32'h0);
    next_cycle();
    @(negedge clk);
    check("lat3 c4 imem_addr", imem_addr, 32'h108);
    for (int c = 4; c <= 6; c++) begin
      check_head($sformatf("lat3 c%0d", c), 1'b0, 32'h0);
      next_cycle();
      @(negedge clk);
    end
    check_head("lat3 c7", 1'b1, 32'h100);
    next_cycle();
    @(negedge clk);
    check_head("lat3 c8", 1'b1, 32'h108);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
